// File: rtl/alu_share_arbiter.sv
// Shares one combinational alu between NUM_REQ valid/ready requesters through a single
// registered result stage. Define ALU_ARB_FIXED_PRIO_EN for fixed priority (default: round-robin).

`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`define ALU_OP_ADD   4'd0
`define ALU_OP_SUB   4'd1
`define ALU_OP_AND   4'd2
`define ALU_OP_OR    4'd3
`define ALU_OP_XOR   4'd4
`define ALU_OP_SLL   4'd5
`define ALU_OP_SRL   4'd6
`define ALU_OP_SRA   4'd7
`define ALU_OP_SLT   4'd8
`define ALU_OP_SLTU  4'd9
`endif

module alu (
    input  logic [`ALU_OP_WIDTH-1:0] op,
    input  logic [31:0]              in1,
    input  logic [31:0]              in2,
    output logic [31:0]              out
);

    // Result selection; op codes outside the table return zero.
    always_comb begin
        out = 32'd0;
        case (op)
            `ALU_OP_ADD:  out = in1 + in2;
            `ALU_OP_SUB:  out = in1 - in2;
            `ALU_OP_AND:  out = in1 & in2;
            `ALU_OP_OR:   out = in1 | in2;
            `ALU_OP_XOR:  out = in1 ^ in2;
            `ALU_OP_SLL:  out = in1 << in2[4:0];
            `ALU_OP_SRL:  out = in1 >> in2[4:0];
            `ALU_OP_SRA:  out = $unsigned($signed(in1) >>> in2[4:0]);
            `ALU_OP_SLT:  out = {31'd0, ($signed(in1) < $signed(in2))};
            `ALU_OP_SLTU: out = {31'd0, (in1 < in2)};
            default:      out = 32'd0;
        endcase
    end

endmodule

module alu_share_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*`ALU_OP_WIDTH-1:0] req_op,
    input  logic [NUM_REQ*32-1:0]            req_in1,
    input  logic [NUM_REQ*32-1:0]            req_in2,
    output logic [NUM_REQ-1:0]               rsp_valid,
    input  logic [NUM_REQ-1:0]               rsp_ready,
    output logic [31:0]                      rsp_data
);

    logic [NUM_REQ-1:0]       rsp_valid_r;
    logic [IDX_W-1:0]         owner_r;
    logic [31:0]              rsp_data_r;

    logic [NUM_REQ-1:0]       grant_s;
    logic [IDX_W-1:0]         grant_idx_s;
    logic                     found_s;
    int                       scan_pos_s;
    logic [IDX_W-1:0]         scan_idx_s;
    logic                     full_s;
    logic                     can_accept_s;
    logic                     accept_s;

    logic [`ALU_OP_WIDTH-1:0] op_arr_s  [NUM_REQ];
    logic [31:0]              in1_arr_s [NUM_REQ];
    logic [31:0]              in2_arr_s [NUM_REQ];
    logic [`ALU_OP_WIDTH-1:0] alu_op_s;
    logic [31:0]              alu_in1_s;
    logic [31:0]              alu_in2_s;
    logic [31:0]              alu_out_s;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]         rr_ptr_r;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_arr_s[g]  = req_op[g*`ALU_OP_WIDTH +: `ALU_OP_WIDTH];
        assign in1_arr_s[g] = req_in1[g*32 +: 32];
        assign in2_arr_s[g] = req_in2[g*32 +: 32];
    end

    // Pick the first valid requester, scanning upward from the start index with wraparound.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        found_s     = 1'b0;
        scan_pos_s  = 0;
        scan_idx_s  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            scan_pos_s = k;
`else
            scan_pos_s = int'(rr_ptr_r) + k;
            if (scan_pos_s >= NUM_REQ) begin
                scan_pos_s = scan_pos_s - NUM_REQ;
            end else begin
                scan_pos_s = scan_pos_s;
            end
`endif
            scan_idx_s = IDX_W'(scan_pos_s);
            if (!found_s && req_valid[scan_idx_s]) begin
                found_s             = 1'b1;
                grant_idx_s         = scan_idx_s;
                grant_s[scan_idx_s] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // A held result only blocks new work while its owner is not taking it.
    assign full_s       = |rsp_valid_r;
    assign can_accept_s = !full_s || rsp_ready[owner_r];
    assign req_ready    = grant_s & {NUM_REQ{can_accept_s}};
    assign accept_s     = |req_ready;

    assign alu_op_s  = op_arr_s[grant_idx_s];
    assign alu_in1_s = in1_arr_s[grant_idx_s];
    assign alu_in2_s = in2_arr_s[grant_idx_s];

    alu u_alu (
        .op  (alu_op_s),
        .in1 (alu_in1_s),
        .in2 (alu_in2_s),
        .out (alu_out_s)
    );

    // Result stage: load on accept (replacing any result drained this cycle), else clear on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= '0;
            owner_r     <= '0;
            rsp_data_r  <= 32'd0;
        end else if (accept_s) begin
            rsp_valid_r <= grant_s;
            owner_r     <= grant_idx_s;
            rsp_data_r  <= alu_out_s;
        end else if (rsp_valid_r[owner_r] && rsp_ready[owner_r]) begin
            rsp_valid_r <= '0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Pointer moves just past the winner, and only when a request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else if (accept_s) begin
            rr_ptr_r <= (grant_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + IDX_W'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;

endmodule
